// File: rtl/popcount_seq_ctrl_if.sv
// Valid/ready word-in, count-out bus for popcount_seq_ctrl.
// The producer/consumer side is master; the controller is slave.
interface popcount_seq_ctrl_if #(
    parameter int unsigned CHUNKS = 4,
    parameter int unsigned RES_W  = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [12*CHUNKS-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [RES_W-1:0]      out_count;
    logic                  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, busy
    );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Counts set bits of a 12*CHUNKS-bit word by running one 12-bit popcount LUT
// over the word's chunks, LSB chunk first, and handing back the total.
module popcount_seq_ctrl #(
    parameter int unsigned CHUNKS = 4,
    parameter int unsigned RES_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    popcount_seq_ctrl_if.slave  bus
);
    localparam int unsigned W     = 12 * CHUNKS;
    localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       sreg_q, sreg_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RES_W-1:0]   out_count_q, out_count_d;
    logic [3:0]         count;

    // 12-bit popcount LUT; its only source is the low chunk of the shift register.
    function automatic logic [3:0] lut_12bit_1s(input logic [11:0] bits);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 12; i++) begin
            c = c + 4'(bits[i]);
        end
        return c;
    endfunction

    always_comb begin
        count = lut_12bit_1s(sreg_q[11:0]);
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_count_d = out_count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d  = acc_q + RES_W'(count);
                sreg_d = sreg_q >> 12;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    out_count_d = acc_q + RES_W'(count);
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_count_q <= out_count_d;
        end
    end

    // in_ready is held low during reset so nothing is accepted on the reset edge.
    always_comb begin
        bus.in_ready  = (state_q == StIdle) && !rst;
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q == StRun) || (state_q == StDone);
        bus.out_count = out_count_q;
    end
endmodule
